lenet_layer_sequencer: RTL and testbench

Top-level scheduler for the LeNet accelerator datapath. It launches each layer stage in order (conv1, pool1, conv2, …) using the per-stage enable / finished / reply_from_next_device handshake. It releases each stage once its output has been consumed and reports run completion and cycle count to the host. It sits between the host control interface and the chain of layer modules, replacing manual wiring of stage k's reply to stage k+1's enable.

---
 rtl/lenet_layer_sequencer.sv | 151 +++++++++++++++
 tb/tb_lenet_layer_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lenet_layer_sequencer.sv
// Layer-chain scheduler: launches each stage in turn, releases it once its output is consumed,
// and reports completion plus run length. Optional per-stage watchdog under `SEQ_TIMEOUT_EN`.
module lenet_layer_sequencer #(
   parameter int NUM_STAGES     = 4,
   parameter int IDX_W          = 2,
   parameter int CNT_W          = 32,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  done_ack,
   input  logic                  clear_error,
   input  logic [NUM_STAGES-1:0] stage_finished,
   output logic [NUM_STAGES-1:0] stage_enable,
   output logic [NUM_STAGES-1:0] stage_reply,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [IDX_W-1:0]      current_stage,
   output logic [CNT_W-1:0]      run_cycles
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LAUNCH = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_ACK    = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;
   localparam logic [2:0] S_ERROR  = 3'd5;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

   logic [2:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic             fin_cur;
   logic             timeout;

   // Only the finished flag of the stage being sequenced matters.
   assign fin_cur = stage_finished[idx_q];

`ifdef SEQ_TIMEOUT_EN
   localparam int WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [WAIT_W-1:0] wait_q, wait_d;

   assign timeout = (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;

   assign timeout        = 1'b0;
   assign unused_timeout = clear_error & (TIMEOUT_CYCLES > 0);
`endif

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_d = state_q;
      idx_d   = idx_q;
      cyc_d   = cyc_q;
`ifdef SEQ_TIMEOUT_EN
      wait_d  = wait_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LAUNCH;
               idx_d   = '0;
               cyc_d   = '0;
            end
         end
         S_LAUNCH: begin
            state_d = S_WAIT;
`ifdef SEQ_TIMEOUT_EN
            wait_d  = '0;
`endif
         end
         S_WAIT: begin
            if (fin_cur) begin
               state_d = (idx_q == LAST_IDX) ? S_DONE : S_ACK;
            end else if (timeout) begin
               state_d = S_ERROR;
            end else begin
`ifdef SEQ_TIMEOUT_EN
               wait_d = wait_q + 1'b1;
`endif
            end
         end
         S_ACK: begin
            if (idx_q == LAST_IDX) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_LAUNCH;
               idx_d   = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            if (done_ack) state_d = S_ACK;
         end
`ifdef SEQ_TIMEOUT_EN
         S_ERROR: begin
            if (clear_error) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // The run counter advances only while the chain is actively being sequenced.
      if ((state_q == S_LAUNCH || state_q == S_WAIT || state_q == S_ACK) && (cyc_q != '1)) begin
         cyc_d = cyc_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cyc_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cyc_q   <= cyc_d;
      end
   end

`ifdef SEQ_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) wait_q <= '0;
      else        wait_q <= wait_d;
   end

   assign error = (state_q == S_ERROR);
`else
   assign error = 1'b0;
`endif

   always_comb begin
      for (int i = 0; i < NUM_STAGES; i++) begin
         stage_enable[i] = (state_q == S_LAUNCH) && (idx_q == IDX_W'(i));
         stage_reply[i]  = (state_q == S_ACK)    && (idx_q == IDX_W'(i));
      end
   end

   assign busy          = (state_q == S_LAUNCH) || (state_q == S_WAIT) ||
                          (state_q == S_ACK)    || (state_q == S_DONE);
   assign done          = (state_q == S_DONE);
   assign current_stage = idx_q;
   assign run_cycles    = cyc_q;

endmodule

// File: tb/tb_lenet_layer_sequencer.sv
// Directed bench for lenet_layer_sequencer with three stub stages (latencies 5/3/4).
// Watchdog scenarios are compiled in when SEQ_TIMEOUT_EN is defined.
module tb_lenet_layer_sequencer;

   localparam int N  = 3;
   localparam int IW = 2;
   localparam int CW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic          done_ack = 1'b0;
   logic          clear_error = 1'b0;
   logic [N-1:0]  stage_finished;
   logic [N-1:0]  stage_enable;
   logic [N-1:0]  stage_reply;
   logic [N-1:0]  force_fin = '0;
   logic          busy;
   logic          done;
   logic          error;
   logic [IW-1:0] current_stage;
   logic [CW-1:0] run_cycles;

   int            checks = 0;
   int            failures = 0;
   int            lat [N] = '{5, 3, 4};
   logic          stall1 = 1'b0;
   int            stub_cnt [N];
   logic [N-1:0]  stub_act;

   lenet_layer_sequencer #(
      .NUM_STAGES(N), .IDX_W(IW), .CNT_W(CW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(rst_n), .start(start), .done_ack(done_ack),
      .clear_error(clear_error), .stage_finished(stage_finished),
      .stage_enable(stage_enable), .stage_reply(stage_reply), .busy(busy),
      .done(done), .error(error), .current_stage(current_stage), .run_cycles(run_cycles)
   );

   always #5 clk = ~clk;

   // Stub stage: finished L+1 cycles after its enable, held until its reply.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stub_act <= '0;
         for (int i = 0; i < N; i++) stub_cnt[i] <= 0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (stage_enable[i]) begin
               stub_act[i] <= 1'b1;
               stub_cnt[i] <= lat[i];
            end else if (stage_reply[i]) begin
               stub_act[i] <= 1'b0;
            end else if (stub_act[i] && stub_cnt[i] > 0) begin
               stub_cnt[i] <= stub_cnt[i] - 1;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         stage_finished[i] = (stub_act[i] && stub_cnt[i] == 0 && !(i == 1 && stall1)) || force_fin[i];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full run with latencies 5/3/4: enables at cycles 0/8/14, replies at 7/13, done from 20.
   task automatic run_seq(input int ack_delay, input bit start_in_wait,
                          input bit start_in_done, input bit spurious);
      logic [N-1:0]  e_en;
      logic [N-1:0]  e_rep;
      logic [IW-1:0] e_idx;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 20; c++) begin
         e_en  = (c == 0) ? 3'b001 : (c == 8) ? 3'b010 : (c == 14) ? 3'b100 : 3'b000;
         e_rep = (c == 7) ? 3'b001 : (c == 13) ? 3'b010 : 3'b000;
         e_idx = (c < 8) ? 2'd0 : (c < 14) ? 2'd1 : 2'd2;
         check("enable", stage_enable, e_en);
         check("reply", stage_reply, e_rep);
         check("busy", busy, 1);
         check("done_low", done, 0);
         check("stage", current_stage, e_idx);
         check("run_cycles", run_cycles, c);
         start     = start_in_wait && (c == 3);
         force_fin = (spurious && c >= 1 && c <= 6) ? 3'b100 : 3'b000;
         tick();
      end
      start     = 1'b0;
      force_fin = '0;
      for (int d = 0; d <= ack_delay; d++) begin
         check("done_held", done, 1);
         check("reply_held", stage_reply, 0);
         check("enable_held", stage_enable, 0);
         check("run_cycles_held", run_cycles, 20);
         check("busy_done", busy, 1);
         start    = start_in_done && (d == 1);
         done_ack = (d == ack_delay);
         tick();
      end
      start    = 1'b0;
      done_ack = 1'b0;
      check("reply_last", stage_reply, 3'b100);
      check("done_in_ack", done, 0);
      check("busy_ack", busy, 1);
      tick();
      check("busy_idle", busy, 0);
      check("enable_idle", stage_enable, 0);
      check("run_cycles_final", run_cycles, 21);
      check("stage_hold", current_stage, 2);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_enable", stage_enable, 0);
      check("rst_reply", stage_reply, 0);
      check("rst_stage", current_stage, 0);
      check("rst_cycles", run_cycles, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Nominal run, then immediate restart with held done and busy-time start pulses.
      run_seq(0, 1'b0, 1'b0, 1'b0);
      run_seq(50, 1'b1, 1'b1, 1'b0);
      run_seq(2, 1'b0, 1'b0, 1'b1);

      // Reset during WAIT of stage 1.
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      check("mid_stage", current_stage, 1);
      check("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mrst_busy", busy, 0);
      check("mrst_stage", current_stage, 0);
      check("mrst_cycles", run_cycles, 0);
      check("mrst_enable", stage_enable, 0);
      check("mrst_reply", stage_reply, 0);
      check("mrst_done", done, 0);
      tick();
      rst_n = 1'b1;
      tick();
      run_seq(1, 1'b0, 1'b0, 1'b0);

`ifdef SEQ_TIMEOUT_EN
      // Stage 1 stuck: WAIT cycles 9..24, ERROR from cycle 25.
      stall1 = 1'b1;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      repeat (9) tick();
      for (int c = 9; c < 25; c++) begin
         check("wd_no_error", error, 0);
         check("wd_busy", busy, 1);
         tick();
      end
      check("wd_error", error, 1);
      check("wd_busy_low", busy, 0);
      check("wd_stage", current_stage, 1);
      check("wd_enable", stage_enable, 0);
      check("wd_reply", stage_reply, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("wd_start_ignored", stage_enable, 0);
      check("wd_error_hold", error, 1);
      clear_error = 1'b1;
      tick();
      clear_error = 1'b0;
      check("wd_cleared", error, 0);
      check("wd_idle", busy, 0);
      stall1 = 1'b0;

      // Stage 1 finishes in its 16th WAIT cycle: finished beats the watchdog.
      lat[1] = 15;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      repeat (25) tick();
      check("co_reply", stage_reply, 3'b010);
      check("co_error", error, 0);
      tick();
      check("co_enable2", stage_enable, 3'b100);
      repeat (6) tick();
      check("co_done", done, 1);
      check("co_cycles", run_cycles, 32);
      done_ack = 1'b1;
      tick();
      done_ack = 1'b0;
      tick();
      check("co_idle", busy, 0);
      check("co_final_cycles", run_cycles, 33);
      lat[1] = 3;
`else
      // Without the watchdog a stuck stage just keeps the sequencer busy.
      stall1 = 1'b1;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      repeat (40) tick();
      check("nowd_error", error, 0);
      check("nowd_busy", busy, 1);
      check("nowd_stage", current_stage, 1);
      rst_n = 1'b0;
      tick();
      rst_n  = 1'b1;
      stall1 = 1'b0;
      tick();
      check("nowd_recover", busy, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
